// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file: two combinational read ports, one write port,
//   write-to-read bypass, optional hardwired-zero register 0, a per-register
//   busy scoreboard and a sequenced bulk-clear engine.
//
// Ports
//   clock               single clock, all state changes on posedge
//   ctrl_reset          synchronous, active-high reset (highest priority)
//   ctrl_writeEnable    write strobe (accepted only while idle)
//   ctrl_writeReg       write index
//   data_writeReg       write data
//   ctrl_readRegA/B     read indices
//   data_readRegA/B     read data (combinational)
//   ctrl_reserveEnable  mark ctrl_reserveReg busy (accepted only while idle)
//   ctrl_reserveReg     index to reserve
//   busy_readRegA/B     busy bit for the addressed registers (combinational)
//   ctrl_clear          start the bulk-clear sequence
//   clear_busy          high while the clear sequence runs
//   state_dbg           clear FSM state (0 = IDLE, 1 = CLEAR), for observation
//
// There is no valid/ready handshake here: every strobe is a single-cycle
// request that is either taken at the next posedge (FSM idle) or dropped.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG0  = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  input  logic                  ctrl_clear,
  output logic                  clear_busy,
  output logic                  state_dbg
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy;

  logic write_ok;
  logic reserve_ok;

  // Requests are only honoured while idle; index 0 is inert when hardwired.
  assign write_ok   = (state == IDLE) && ctrl_writeEnable &&
                      !(ZERO_REG0 && (ctrl_writeReg == '0));
  assign reserve_ok = (state == IDLE) && ctrl_reserveEnable &&
                      !(ZERO_REG0 && (ctrl_reserveReg == '0));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy  <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_ok) begin
            mem[ctrl_writeReg]  <= data_writeReg;
            busy[ctrl_writeReg] <= 1'b0;
          end
          // Issued after the write so a same-index reserve leaves busy set.
          if (reserve_ok) busy[ctrl_reserveReg] <= 1'b1;
          if (ctrl_clear) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          mem[idx]  <= '0;
          busy[idx] <= 1'b0;
          idx       <= idx + 1'b1;  // wraps to 0 as the last entry is cleared
          if (idx == LAST_IDX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Resolve one read port: {busy, data}. write_ok already excludes CLEAR and
  // a hardwired register 0, so the bypass needs no extra qualification.
  function automatic logic [DATA_WIDTH:0] resolve(
    input logic [ADDR_WIDTH-1:0] ra,
    input logic [DATA_WIDTH-1:0] stored_data,
    input logic                  stored_busy,
    input logic                  w_ok,
    input logic [ADDR_WIDTH-1:0] w_idx,
    input logic [DATA_WIDTH-1:0] w_data,
    input logic                  r_ok,
    input logic [ADDR_WIDTH-1:0] r_idx
  );
    logic [DATA_WIDTH:0] res;
    res = {stored_busy, stored_data};
    if (ZERO_REG0 && (ra == '0)) begin
      res = '0;
    end else if (BYPASS && w_ok && (w_idx == ra)) begin
      res = {(r_ok && (r_idx == ra)), w_data};
    end
    return res;
  endfunction

  always_comb begin
    {busy_readRegA, data_readRegA} = resolve(ctrl_readRegA, mem[ctrl_readRegA],
                                             busy[ctrl_readRegA], write_ok,
                                             ctrl_writeReg, data_writeReg,
                                             reserve_ok, ctrl_reserveReg);
    {busy_readRegB, data_readRegB} = resolve(ctrl_readRegB, mem[ctrl_readRegB],
                                             busy[ctrl_readRegB], write_ok,
                                             ctrl_writeReg, data_writeReg,
                                             reserve_ok, ctrl_reserveReg);
  end

  assign clear_busy = (state == CLEAR);
  assign state_dbg  = (state == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Drives two register files (bypass on / bypass off, both with a hardwired
//   register 0) from the same stimulus and compares every combinational
//   output each cycle against a behavioural model of the register contents,
//   busy flags and clear progress.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          ctrl_reset;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic          ctrl_reserveEnable;
  logic [AW-1:0] ctrl_reserveReg;
  logic          ctrl_clear;

  logic [DW-1:0] a_data, b_data, nb_a_data, nb_b_data;
  logic          a_busy, b_busy, nb_a_busy, nb_b_busy;
  logic          clr_busy, nb_clr_busy, st_dbg, nb_st_dbg;

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG0(1'b1), .BYPASS(1'b1)) u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(a_data), .data_readRegB(b_data),
    .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
    .busy_readRegA(a_busy), .busy_readRegB(b_busy),
    .ctrl_clear(ctrl_clear), .clear_busy(clr_busy), .state_dbg(st_dbg)
  );

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG0(1'b1), .BYPASS(1'b0)) u_nb (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(nb_a_data), .data_readRegB(nb_b_data),
    .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
    .busy_readRegA(nb_a_busy), .busy_readRegB(nb_b_busy),
    .ctrl_clear(ctrl_clear), .clear_busy(nb_clr_busy), .state_dbg(nb_st_dbg)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_clr;        // clear sequence in progress
  int            m_pos;        // next entry the clear sequence wipes

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a read port should show this cycle, given the stored model and the
  // requests currently on the inputs.
  function automatic void predict(input int ra, input bit byp,
                                  output logic [DW-1:0] d, output logic b);
    bit wacc, racc;
    wacc = ctrl_writeEnable && !m_clr && (int'(ctrl_writeReg) != 0);
    racc = ctrl_reserveEnable && !m_clr && (int'(ctrl_reserveReg) != 0);
    if (ra == 0) begin
      d = '0; b = 1'b0;
    end else if (byp && wacc && int'(ctrl_writeReg) == ra) begin
      d = data_writeReg;
      b = racc && int'(ctrl_reserveReg) == ra;
    end else begin
      d = m_reg[ra]; b = m_busy[ra];
    end
  endfunction

  // Apply the effect of one posedge to the model (inputs still stable).
  function automatic void model_edge();
    if (ctrl_reset) begin
      foreach (m_reg[i]) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      m_clr = 1'b0; m_pos = 0;
    end else if (m_clr) begin
      m_reg[m_pos] = '0; m_busy[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == DEPTH) begin m_clr = 1'b0; m_pos = 0; end
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_reg[ctrl_writeReg]  = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_reserveEnable && ctrl_reserveReg != 0) m_busy[ctrl_reserveReg] = 1'b1;
      if (ctrl_clear) begin m_clr = 1'b1; m_pos = 0; end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit we, input int wr, input logic [DW-1:0] wd,
                       input bit rv, input int rr, input int ra, input int rb,
                       input bit clr, input bit rst);
    ctrl_writeEnable   = we;
    ctrl_writeReg      = wr[AW-1:0];
    data_writeReg      = wd;
    ctrl_reserveEnable = rv;
    ctrl_reserveReg    = rr[AW-1:0];
    ctrl_readRegA      = ra[AW-1:0];
    ctrl_readRegB      = rb[AW-1:0];
    ctrl_clear         = clr;
    ctrl_reset         = rst;
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] d;
    logic          b;
    #2;
    predict(int'(ctrl_readRegA), 1'b1, d, b);
    chk({tag, "/a_data"}, a_data, d);
    chk({tag, "/a_busy"}, DW'(a_busy), DW'(b));
    predict(int'(ctrl_readRegB), 1'b1, d, b);
    chk({tag, "/b_data"}, b_data, d);
    chk({tag, "/b_busy"}, DW'(b_busy), DW'(b));
    predict(int'(ctrl_readRegA), 1'b0, d, b);
    chk({tag, "/nb_a_data"}, nb_a_data, d);
    chk({tag, "/nb_a_busy"}, DW'(nb_a_busy), DW'(b));
    predict(int'(ctrl_readRegB), 1'b0, d, b);
    chk({tag, "/nb_b_data"}, nb_b_data, d);
    chk({tag, "/nb_b_busy"}, DW'(nb_b_busy), DW'(b));
    chk({tag, "/clear_busy"}, DW'(clr_busy), DW'(m_clr));
    chk({tag, "/nb_clear_busy"}, DW'(nb_clr_busy), DW'(m_clr));
    chk({tag, "/state"}, DW'(st_dbg), DW'(m_clr));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic cycle(input string tag);
    check_outputs(tag);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    logic [DW-1:0] rd;

    drive(0, 0, '0, 0, 0, 0, 0, 0, 1);
    m_clr = 1'b0; m_pos = 0;
    tick();
    tick();

    // Reset state
    drive(0, 0, '0, 0, 0, 5, 0, 0, 0);
    check_outputs("reset");
    chk("reset/a_lit", a_data, 32'h0);
    chk("reset/clr_lit", DW'(clr_busy), 32'h0);
    tick();

    // Write then read back r5
    drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 2, 0, 0);
    cycle("t1_wr");
    drive(0, 0, '0, 0, 0, 5, 5, 0, 0);
    check_outputs("t1_rd");
    chk("t1/a_lit", a_data, 32'hDEADBEEF);
    chk("t1/busy_lit", DW'(a_busy), 32'h0);
    tick();

    // Register 0 is hardwired
    drive(1, 0, 32'h1234, 1, 0, 0, 0, 0, 0);
    cycle("t2_wr0");
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    check_outputs("t2_rd0");
    chk("t2/a_lit", a_data, 32'h0);
    chk("t2/b_busy_lit", DW'(b_busy), 32'h0);
    tick();

    // Bypass: new data on bypassing file, old data on the other
    drive(1, 7, 32'h11111111, 0, 0, 0, 0, 0, 0);
    cycle("t3_pre");
    drive(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 0, 0);
    check_outputs("t3_byp");
    chk("t3/byp_lit", b_data, 32'hA5A5A5A5);
    chk("t3/nobyp_lit", nb_b_data, 32'h11111111);
    tick();

    // Busy scoreboard on r3
    drive(0, 0, '0, 1, 3, 3, 3, 0, 0);
    cycle("t4_rsv");
    drive(0, 0, '0, 0, 0, 3, 3, 0, 0);
    check_outputs("t4_busy");
    chk("t4/busy_lit", DW'(a_busy), 32'h1);
    tick();
    drive(1, 3, 32'd9, 0, 0, 3, 0, 0, 0);
    cycle("t4_wr");
    drive(0, 0, '0, 0, 0, 3, 0, 0, 0);
    check_outputs("t4_free");
    chk("t4/free_lit", DW'(a_busy), 32'h0);
    chk("t4/data_lit", a_data, 32'd9);
    tick();
    drive(1, 3, 32'd77, 1, 3, 3, 3, 0, 0);
    cycle("t4_both");
    drive(0, 0, '0, 0, 0, 3, 3, 0, 0);
    check_outputs("t4_both_rd");
    chk("t4/both_busy_lit", DW'(a_busy), 32'h1);
    chk("t4/both_data_lit", a_data, 32'd77);
    tick();

    // Fill, reserve odd registers, then bulk clear
    for (int i = 1; i < DEPTH; i++) begin
      drive(1, i, $urandom | 32'h1, i[0], i, i, (i * 7) % DEPTH, 0, 0);
      cycle("t5_fill");
    end
    drive(0, 0, '0, 0, 0, 1, 2, 1, 0);
    cycle("t5_start");
    cnt = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(k == 5, 9, 32'hBAD0BAD0, k == 6, 11, 9, 11, k == 7, 0);
      check_outputs("t5_run");
      if (clr_busy) cnt++;
      tick();
    end
    chk("t5/len", DW'(cnt), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, 0, 0, i, DEPTH - 1 - i, 0, 0);
      check_outputs("t5_after");
      chk("t5/zero_lit", a_data, 32'h0);
      chk("t5/busy_lit", DW'(a_busy), 32'h0);
      tick();
    end

    // Reset aborts a running clear; a new clear starts over
    for (int i = 1; i < 12; i++) begin
      drive(1, i, $urandom, 1, i, 0, 0, 0, 0);
      cycle("t6_fill");
    end
    drive(0, 0, '0, 0, 0, 0, 0, 1, 0);
    cycle("t6_start");
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, '0, 0, 0, 10, 11, 0, 0);
      cycle("t6_run");
    end
    drive(0, 0, '0, 0, 0, 10, 11, 0, 1);
    cycle("t6_rst");
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, 0, 0, i, i, 0, 0);
      check_outputs("t6_after");
      chk("t6/zero_lit", a_data, 32'h0);
      chk("t6/clr_lit", DW'(clr_busy), 32'h0);
      tick();
    end
    drive(1, 4, 32'h4444, 1, 6, 4, 6, 0, 0);
    cycle("t6_refill");
    drive(0, 0, '0, 0, 0, 4, 6, 1, 0);
    cycle("t6_restart");
    cnt = 0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(0, 0, '0, 0, 0, 4, 6, 0, 0);
      check_outputs("t6_rerun");
      if (clr_busy) cnt++;
      tick();
    end
    chk("t6/len", DW'(cnt), 32'd32);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rd = $urandom;
      drive($urandom_range(0, 1), $urandom_range(0, 7), rd,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
      cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
